// File: rtl/mem_access_unit.sv
// Load/store sequencer between the pipeline and the byte-addressed data memory.
// Build option: define MISALIGN_TRAP_EN to report misaligned halfword/word accesses as errors.
module mem_access_unit #(
  parameter int MEM_BYTES = 256,
  parameter int FUNCT_W   = 3
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_store,
  input  logic [FUNCT_W-1:0] req_funct3,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_err,
  output logic [31:0]        mem_address,
  output logic [31:0]        mem_datain,
  output logic [3:0]         mem_wme,
  input  logic [7:0]         mem_do0,
  input  logic [7:0]         mem_do1,
  input  logic [7:0]         mem_do2,
  input  logic [7:0]         mem_do3
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  localparam logic [FUNCT_W-1:0] F_B  = FUNCT_W'(3'b000);
  localparam logic [FUNCT_W-1:0] F_H  = FUNCT_W'(3'b001);
  localparam logic [FUNCT_W-1:0] F_W  = FUNCT_W'(3'b010);
  localparam logic [FUNCT_W-1:0] F_BU = FUNCT_W'(3'b100);
  localparam logic [FUNCT_W-1:0] F_HU = FUNCT_W'(3'b101);

  state_e             state_q, state_d;
  logic               store_q, store_d;
  logic [FUNCT_W-1:0] funct3_q, funct3_d;
  logic               err_q, err_d;
  logic [31:0]        mem_address_q, mem_address_d;
  logic [31:0]        mem_datain_q, mem_datain_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;

  logic [2:0]  req_size;
  logic [32:0] req_last_byte;
  logic        req_illegal;
  logic        req_range_err;
  logic        req_misalign;
  logic [31:0] load_ext;

  // Request classification, evaluated only when a request is accepted in IDLE.
  always_comb begin
    req_size    = 3'd1;
    req_illegal = 1'b0;
    case (req_funct3)
      F_B:       req_size = 3'd1;
      F_H:       req_size = 3'd2;
      F_W:       req_size = 3'd4;
      F_BU:      begin req_size = 3'd1; req_illegal = req_store; end
      F_HU:      begin req_size = 3'd2; req_illegal = req_store; end
      default:   req_illegal = 1'b1;
    endcase
    // 33-bit sum so that an access wrapping past 0xFFFFFFFF is caught as out of range.
    req_last_byte = {1'b0, req_addr} + 33'(req_size) - 33'd1;
    req_range_err = req_last_byte >= 33'(MEM_BYTES);
`ifdef MISALIGN_TRAP_EN
    req_misalign = ((req_size == 3'd2) && req_addr[0]) ||
                   ((req_size == 3'd4) && (req_addr[1:0] != 2'b00));
`else
    req_misalign = 1'b0;
`endif
  end

  always_comb begin
    load_ext = '0;
    case (funct3_q)
      F_B:     load_ext = {{24{mem_do0[7]}}, mem_do0};
      F_BU:    load_ext = {24'b0, mem_do0};
      F_H:     load_ext = {{16{mem_do1[7]}}, mem_do1, mem_do0};
      F_HU:    load_ext = {16'b0, mem_do1, mem_do0};
      F_W:     load_ext = {mem_do3, mem_do2, mem_do1, mem_do0};
      default: load_ext = '0;
    endcase
  end

  // NOTE: every signal gets its hold value first so no path through the case leaves it unassigned (no latches).
  always_comb begin
    state_d       = state_q;
    store_d       = store_q;
    funct3_d      = funct3_q;
    err_d         = err_q;
    mem_address_d = mem_address_q;
    mem_datain_d  = mem_datain_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d       = ACCESS;
          store_d       = req_store;
          funct3_d      = req_funct3;
          err_d         = req_illegal || req_range_err || req_misalign;
          mem_address_d = req_addr;
          mem_datain_d  = req_wdata;
        end
      end
      ACCESS: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_q;
        rsp_rdata_d = (store_q || err_q) ? 32'd0 : load_ext;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q       <= IDLE;
      store_q       <= 1'b0;
      funct3_q      <= '0;
      err_q         <= 1'b0;
      mem_address_q <= '0;
      mem_datain_q  <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      store_q       <= store_d;
      funct3_q      <= funct3_d;
      err_q         <= err_d;
      mem_address_q <= mem_address_d;
      mem_datain_q  <= mem_datain_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  // Write enables come only from registered state, so Reset drops them asynchronously.
  always_comb begin
    mem_wme = 4'b0000;
    if ((state_q == ACCESS) && store_q && !err_q) begin
      case (funct3_q)
        F_B:     mem_wme = 4'b0001;
        F_H:     mem_wme = 4'b0011;
        F_W:     mem_wme = 4'b1111;
        default: mem_wme = 4'b0000;
      endcase
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign mem_address = mem_address_q;
  assign mem_datain  = mem_datain_q;

endmodule
